// File: rtl/fpu_op_sequencer.sv
// fpu_op_sequencer: buffers ops, issues one per clock into a fixed-latency FPU, retires tagged results in order.
// Define FPU_SEQ_STATUS_EN to add out_status decode, sticky status_flags and status_clr.
module fpu_op_sequencer #(
  parameter int IQ_DEPTH = 4,
  parameter int RQ_DEPTH = 4,
  parameter int FPU_LATENCY = 2,
  parameter int TAG_W = 4
) (
  input  logic CLK,
  input  logic RST,
  input  logic in_valid,
  output logic in_ready,
  input  logic [31:0] in_op1,
  input  logic [31:0] in_op2,
  input  logic [1:0] in_operation,
  output logic [31:0] fpu_operand1,
  output logic [31:0] fpu_operand2,
  output logic [1:0] fpu_operation,
  input  logic [31:0] fpu_result,
  output logic out_valid,
  input  logic out_ready,
  output logic [31:0] out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [$clog2(RQ_DEPTH):0] inflight
`ifdef FPU_SEQ_STATUS_EN
  ,
  input  logic status_clr,
  output logic [2:0] out_status,
  output logic [2:0] status_flags
`endif
);
  localparam int IA = $clog2(IQ_DEPTH);
  localparam int RA = $clog2(RQ_DEPTH);
  logic [31:0] iq_op1 [IQ_DEPTH];
  logic [31:0] iq_op2 [IQ_DEPTH];
  logic [1:0] iq_opn [IQ_DEPTH];
  logic [TAG_W-1:0] iq_tag [IQ_DEPTH];
  logic [IA-1:0] iq_wp, iq_rp;
  logic [IA:0] iq_cnt, iq_cnt_nxt;
  logic [31:0] rq_res [RQ_DEPTH];
  logic [TAG_W-1:0] rq_tag [RQ_DEPTH];
  logic [RA-1:0] rq_wp, rq_rp;
  logic [RA:0] rq_cnt;
  logic [RA+1:0] credit;
  logic [TAG_W-1:0] tag_cnt;
  logic [FPU_LATENCY-1:0] sr_vld;
  logic [TAG_W-1:0] sr_tag [FPU_LATENCY];
  logic push, issue, capture, pop;
  assign push = in_valid && in_ready;
  // Ops in the FPU plus results waiting must never exceed the result FIFO, since the FPU cannot stall.
  assign credit = (RA+2)'(inflight) + (RA+2)'(rq_cnt);
  assign issue = iq_cnt != '0 && credit < (RA+2)'(RQ_DEPTH);
  assign capture = sr_vld[FPU_LATENCY-1];
  assign out_valid = rq_cnt != '0;
  assign pop = out_valid && out_ready;
  assign out_result = out_valid ? rq_res[rq_rp] : '0;
  assign out_tag = out_valid ? rq_tag[rq_rp] : '0;
  assign iq_cnt_nxt = iq_cnt + (IA+1)'(push) - (IA+1)'(issue);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      in_ready <= 1'b0;
      iq_wp <= '0;
      iq_rp <= '0;
      iq_cnt <= '0;
      rq_wp <= '0;
      rq_rp <= '0;
      rq_cnt <= '0;
      tag_cnt <= '0;
      inflight <= '0;
      sr_vld <= '0;
      fpu_operand1 <= '0;
      fpu_operand2 <= '0;
      fpu_operation <= '0;
    end else begin
      in_ready <= iq_cnt_nxt != (IA+1)'(IQ_DEPTH);
      iq_cnt <= iq_cnt_nxt;
      iq_wp <= iq_wp + IA'(push);
      iq_rp <= iq_rp + IA'(issue);
      tag_cnt <= tag_cnt + TAG_W'(push);
      rq_wp <= rq_wp + RA'(capture);
      rq_rp <= rq_rp + RA'(pop);
      rq_cnt <= rq_cnt + (RA+1)'(capture) - (RA+1)'(pop);
      inflight <= inflight + (RA+1)'(issue) - (RA+1)'(capture);
      sr_vld <= FPU_LATENCY'({sr_vld, issue});
      if (issue) begin
        fpu_operand1 <= iq_op1[iq_rp];
        fpu_operand2 <= iq_op2[iq_rp];
        fpu_operation <= iq_opn[iq_rp];
      end
    end
  always_ff @(posedge CLK) begin
    if (push) begin
      iq_op1[iq_wp] <= in_op1;
      iq_op2[iq_wp] <= in_op2;
      iq_opn[iq_wp] <= in_operation;
      iq_tag[iq_wp] <= tag_cnt;
    end
    if (capture) begin
      rq_res[rq_wp] <= fpu_result;
      rq_tag[rq_wp] <= sr_tag[FPU_LATENCY-1];
    end
    sr_tag[0] <= iq_tag[iq_rp];
    for (int i = 1; i < FPU_LATENCY; i++) sr_tag[i] <= sr_tag[i-1];
  end
`ifdef FPU_SEQ_STATUS_EN
  assign out_status = {&out_result[30:23] && |out_result[22:0],
                       &out_result[30:23] && ~|out_result[22:0],
                       ~|out_result[30:0]};
  always_ff @(posedge CLK or posedge RST)
    if (RST) status_flags <= '0;
    else if (status_clr) status_flags <= '0;
    else if (pop) status_flags <= status_flags | out_status;
`endif
endmodule

// File: tb/tb_fpu_op_sequencer.sv
// tb_fpu_op_sequencer: directed table-driven bench with an in-order scoreboard and a table-lookup FPU model.
module tb_fpu_op_sequencer;
  localparam int IQ = 4, RQ = 4, LAT = 2, TW = 4;
  logic CLK = 1'b0, RST = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [31:0] in_op1 = '0, in_op2 = '0;
  logic [1:0] in_operation = '0;
  logic [31:0] fpu_operand1, fpu_operand2, fpu_result, out_result;
  logic [1:0] fpu_operation;
  logic [TW-1:0] out_tag;
  logic [$clog2(RQ):0] inflight;
`ifdef FPU_SEQ_STATUS_EN
  logic status_clr = 1'b0;
  logic [2:0] out_status, status_flags;
`endif
  fpu_op_sequencer #(.IQ_DEPTH(IQ), .RQ_DEPTH(RQ), .FPU_LATENCY(LAT), .TAG_W(TW)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_operation(in_operation),
    .fpu_operand1(fpu_operand1), .fpu_operand2(fpu_operand2), .fpu_operation(fpu_operation),
    .fpu_result(fpu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .inflight(inflight)
`ifdef FPU_SEQ_STATUS_EN
    , .status_clr(status_clr), .out_status(out_status), .status_flags(status_flags)
`endif
  );
  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] op1; logic [31:0] op2; logic [1:0] opn; logic [31:0] res; } vec_t;
  vec_t vec [8];
  int total = 0, bad = 0;
  logic [31:0] exp_res_q [$];
  logic [TW-1:0] exp_tag_q [$];
  logic [TW-1:0] tag_m = '0;
  logic [31:0] fpu_pipe;
  int n, hi;
  logic [31:0] infl1;

  // FPU stand-in: known IEEE results by lookup, one register stage so results land LAT edges after inputs change
  function automatic logic [31:0] fpu_f(logic [31:0] a, logic [31:0] b, logic [1:0] o);
    fpu_f = 32'hDEADBEEF;
    for (int i = 0; i < 8; i++)
      if (vec[i].op1 == a && vec[i].op2 == b && vec[i].opn == o) fpu_f = vec[i].res;
  endfunction
  always @(posedge CLK) fpu_pipe <= fpu_f(fpu_operand1, fpu_operand2, fpu_operation);
  assign fpu_result = fpu_pipe;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge CLK)
    if (!RST && out_valid && out_ready) begin
      if (exp_res_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %h want none", out_result);
      end else begin
        chk("out_result", out_result, exp_res_q.pop_front());
        chk("out_tag", 32'(out_tag), 32'(exp_tag_q.pop_front()));
      end
    end

  task automatic send(int i);
    int w = 0;
    in_op1 = vec[i].op1;
    in_op2 = vec[i].op2;
    in_operation = vec[i].opn;
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(posedge CLK);
      #1;
      w++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got in_ready=0 want 1");
    end else begin
      exp_res_q.push_back(vec[i].res);
      exp_tag_q.push_back(tag_m);
      tag_m++;
    end
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while (exp_res_q.size() != 0 && w < 200) begin
      @(posedge CLK);
      #1;
      w++;
    end
    chk("drain_left", exp_res_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec[0] = '{32'h3FC00000, 32'h40000000, 2'b10, 32'h40400000};
    vec[1] = '{32'h3F800000, 32'h3F800000, 2'b00, 32'h40000000};
    vec[2] = '{32'h40400000, 32'h3F800000, 2'b01, 32'h40000000};
    vec[3] = '{32'h40000000, 32'h40000000, 2'b10, 32'h40800000};
    vec[4] = '{32'h40800000, 32'h40000000, 2'b11, 32'h40000000};
    vec[5] = '{32'h3F800000, 32'h00000000, 2'b11, 32'h7F800000};
    vec[6] = '{32'h00000000, 32'h00000000, 2'b00, 32'h00000000};
    vec[7] = '{32'h40000000, 32'h3F800000, 2'b00, 32'h40400000};
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_fpu_op1", fpu_operand1, 0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    send(0);
    n = 0;
    infl1 = '1;
    while (!out_valid && n < 10) begin
      @(posedge CLK);
      #1;
      n++;
      if (n == 1) infl1 = 32'(inflight);
    end
    chk("single_latency", n, LAT + 1);
    chk("single_inflight", infl1, 1);
    chk("single_result", out_result, 32'h40400000);
    chk("single_tag", 32'(out_tag), 0);
    out_ready = 1'b1;
    drain();

    fork
      for (int k = 0; k < 10; k++) send(1);
      begin
        n = 0;
        hi = 0;
        while (!out_valid && n < 20) begin
          @(negedge CLK);
          n++;
        end
        for (int k = 0; k < 10; k++) begin
          hi += 32'(out_valid);
          @(negedge CLK);
        end
        chk("stream_no_gaps", hi, 10);
      end
    join
    drain();

    for (int k = 0; k < 8; k++) send(k);
    drain();

    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) send(k);
    repeat (3) @(posedge CLK);
    #1;
    chk("bp_in_ready", in_ready, 0);
    chk("bp_inflight", inflight, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_head", out_result, vec[0].res);
    out_ready = 1'b1;
    for (int k = 8; k < 12; k++) send(k % 8);
    drain();

    out_ready = 1'b0;
    for (int k = 2; k < 5; k++) send(k);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_result", out_result, 0);
    chk("mid_rst_out_tag", 32'(out_tag), 0);
    chk("mid_rst_inflight", inflight, 0);
    chk("mid_rst_fpu_op1", fpu_operand1, 0);
    chk("mid_rst_fpu_op2", fpu_operand2, 0);
    chk("mid_rst_fpu_opn", 32'(fpu_operation), 0);
    exp_res_q.delete();
    exp_tag_q.delete();
    tag_m = '0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    chk("mid_rst_ready_after", in_ready, 1);
    chk("mid_rst_valid_after", out_valid, 0);
    out_ready = 1'b1;
    hi = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      hi += 32'(out_valid);
    end
    chk("mid_rst_no_stale", hi, 0);

    for (int k = 0; k < 18; k++) send(k % 8);
    drain();
    chk("wrap_next_tag", 32'(tag_m), 2);

`ifdef FPU_SEQ_STATUS_EN
    out_ready = 1'b0;
    send(5);
    n = 0;
    while (!out_valid && n < 10) begin
      @(posedge CLK);
      #1;
      n++;
    end
    chk("status_div0", 32'(out_status), 32'(3'b010));
    chk("flags_before_pop", 32'(status_flags), 0);
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    chk("flags_after_pop", 32'(status_flags), 32'(3'b010));
    status_clr = 1'b1;
    @(posedge CLK);
    #1;
    status_clr = 1'b0;
    chk("flags_cleared", 32'(status_flags), 0);
    out_ready = 1'b1;
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
- Issue/retire stage directly upstream of FPU.
- Buffers incoming operand triples {Operand1, Operand2, Operation} in an input FIFO.
- Drives FPU inputs one op per clock and tracks the FPU's fixed pipeline latency.
- Captures each FPU Result into an in-order result FIFO and returns it with a sequence tag, using valid/ready handshakes on both sides.

Parameters:
- IQ_DEPTH, 4, input FIFO entries; power of 2, ≥2.
- RQ_DEPTH, 4, result FIFO entries; power of 2, ≥2.
- FPU_LATENCY, 2, CLK edges from FPU input change to valid FPU Result; ≥1.
- TAG_W, 4, sequence tag width.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream op valid.
- in_ready  out  1  input FIFO can accept.
- in_op1  in  32  IEEE-754 single operand 1.
- in_op2  in  32  IEEE-754 single operand 2.
- in_operation  in  2  00 add, 01 sub, 10 mul, 11 div.
- fpu_operand1  out  32  to FPU Operand1.
- fpu_operand2  out  32  to FPU Operand2.
- fpu_operation  out  2  to FPU Operation.
- fpu_result  in  32  from FPU Result.
- out_valid  out  1  result FIFO non-empty.
- out_ready  in  1  downstream accepts.
- out_result  out  32  head result.
- out_tag  out  TAG_W  tag of head result.
- inflight  out  $clog2(RQ_DEPTH)+1  ops issued and not yet captured.

Behaviour:
- Reset (async, while RST=1):
  - Both FIFOs empty; tag counter, inflight and latency shift register all 0.
  - fpu_operand1/2 = 0, fpu_operation = 0.
  - in_ready = 0, out_valid = 0, out_result = 0, out_tag = 0.
  - Reset mid-operation discards queued and in-flight ops; no result is produced for them.
- Accept:
  - in_ready = !iq_full (registered, no same-cycle bypass). When full, a push is refused even if a pop occurs that cycle.
  - On in_valid&&in_ready, push {op1, op2, operation, tag}; tag counter then increments mod 2^TAG_W (15 wraps to 0).
- Issue:
  - Condition: iq not empty AND (inflight + rq_count) < RQ_DEPTH. This credit rule guarantees the result FIFO never overflows, because the FPU cannot stall.
  - On issue, the head is registered onto fpu_* ports at the edge, and a 1 with its tag enters the FPU_LATENCY-deep valid/tag shift register.
  - When not issuing, fpu_* ports hold their last values; the shift register shifts in 0.
  - At most one issue per cycle.
- Capture: when the shift register's last stage holds 1, fpu_result plus its tag are written to the result FIFO at that edge.
- Counters: inflight increments on issue, decrements on capture; both in one cycle leaves it unchanged.
- Output:
  - out_valid = rq not empty; out_result/out_tag show the head.
  - Pop on out_valid&&out_ready.
  - Capture and pop in the same cycle are both honoured.
- Latency: op accepted at edge t → fpu_* updated at edge t+1 → captured at edge t+1+FPU_LATENCY → out_valid high after that edge. Minimum in→out = FPU_LATENCY+1 edges.
- Ordering: results retire strictly in acceptance order; tags are consecutive mod 2^TAG_W.
- Back-to-back throughput: 1 op/cycle when out_ready stays high.

Optional Feature:
- Macro FPU_SEQ_STATUS_EN.
- Defined:
  - Adds out_status [2:0] = {nan, inf, zero}, decoded from out_result. nan: exp=FF, mant≠0. inf: exp=FF, mant=0. zero: exp=0, mant=0, either sign.
  - Adds a sticky status_flags [2:0] register, which ORs in each popped result's status.
  - Adds status_clr input (1 bit); clear wins over a same-cycle set.
  - status_flags reset to 0.
- Undefined: these ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: RST=1 pulse mid-stream with 3 ops queued → all outputs 0 immediately; after release, in_ready=1, out_valid=0, and no stale result appears within 10 cycles.
- Single op: op1=0x3FC00000, op2=0x40000000, operation=10 (mul) → out_result=0x40400000, out_tag=0, out_valid first high FPU_LATENCY+1 edges after accept.
- Stream of 10 ops (add 0x3F800000+0x3F800000 repeated), out_ready=1 → ten results 0x40000000, tags 0..9, one per cycle, no gaps.
- Backpressure: out_ready=0, push 12 ops → exactly RQ_DEPTH results held, inflight returns to 0, in_ready drops after IQ_DEPTH further accepts. Then out_ready=1 → all 12 retire in order with no loss.
- Tag wrap: 18 ops with TAG_W=4 → tags 0..15, 0, 1.
- FPU_SEQ_STATUS_EN: div 0x3F800000/0x00000000 → out_status=3'b010 and status_flags[1] set; status_clr=1 → status_flags=0.
